// File: rtl/particle_stream_pkg.sv
// Shared types and constants for the particle stream transmit path.
// Optional coordinate clamping is enabled with PARTICLE_STREAM_CLAMP_EN.
package particle_stream_pkg;
    localparam int P_DIMS = 2;
    localparam logic [15:0] FP16_EXP_MASK = 16'h7C00;
    localparam int FP16_SIGN_BIT = 15;

    typedef logic [15:0] fp16_t;
    typedef fp16_t [P_DIMS-1:0] pos_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } stream_state_t;
endpackage

// File: rtl/particle_streamer_clamp.sv
// Single fp16 coordinate limiter: saturates magnitude to a bound, keeps sign.
// Used by particle_streamer only when PARTICLE_STREAM_CLAMP_EN is defined.
module fp16_clamp
    import particle_stream_pkg::*;
(
    input  fp16_t       i_val,
    input  logic [14:0] i_bound_mag,
    output fp16_t       o_val
);
    logic w_over;
    logic w_nan;

    always_comb begin
        w_nan  = (i_val & FP16_EXP_MASK) == FP16_EXP_MASK;
        w_over = i_val[14:0] > i_bound_mag;
        if (w_over || w_nan)
            o_val = {i_val[FP16_SIGN_BIT], i_bound_mag};
        else
            o_val = i_val;
    end
endmodule

// File: rtl/particle_streamer.sv
// Streams particle positions from BRAM to the renderer, one beat per cycle.
// Define PARTICLE_STREAM_CLAMP_EN to clamp coordinates (adds one stage).
module particle_streamer
    import particle_stream_pkg::*;
#(
    parameter int          DIMS          = P_DIMS,
    parameter int          COUNTER_SIZE  = 16,
    parameter int          MAX_PARTICLES = 1024,
    parameter int          MEM_LATENCY   = 2,
    parameter logic [31:0] BOUND         = 32'h4000_4000
) (
    input  logic                    clk_in,
    input  logic                    sys_rst,
    input  logic                    new_frame,
    input  logic [15:0]             particle_count,
    output logic [COUNTER_SIZE-1:0] mem_addr,
    output logic                    mem_rd_en,
    input  logic [16*DIMS-1:0]      mem_data,
    output logic [16*DIMS-1:0]      particle_data_out,
    output logic [COUNTER_SIZE-1:0] particle_index_out,
    output logic                    valid_particle,
    output logic                    frame_complete,
    output logic                    busy,
    output logic [7:0]              dropped_frames
);
    stream_state_t r_state;
    stream_state_t w_next;

    logic [COUNTER_SIZE-1:0] r_cnt;
    logic [COUNTER_SIZE-1:0] r_last;
    logic [16:0]             w_n;
    logic                    w_fetch;

    logic [MEM_LATENCY-1:0]  r_vld;
    logic [COUNTER_SIZE-1:0] r_idx [MEM_LATENCY];

    logic [16*DIMS-1:0]      w_data;
    logic [COUNTER_SIZE-1:0] w_idx;
    logic                    w_vld;
    logic                    w_pipe_busy;

    assign w_n = ({1'b0, particle_count} > 17'(MAX_PARTICLES))
               ? 17'(MAX_PARTICLES) : {1'b0, particle_count};

    assign w_fetch   = r_state == FETCH;
    assign mem_rd_en = w_fetch;
    assign mem_addr  = w_fetch ? r_cnt : '0;
    assign busy      = r_state != IDLE;
    assign frame_complete = r_state == DONE;

`ifdef PARTICLE_STREAM_CLAMP_EN
    pos_t                    w_raw;
    pos_t                    w_clamped;
    pos_t                    w_bound;
    logic [16*DIMS-1:0]      r_c_data;
    logic [COUNTER_SIZE-1:0] r_c_idx;
    logic                    r_c_vld;

    assign w_raw   = pos_t'(mem_data);
    assign w_bound = pos_t'(BOUND);

    for (genvar g = 0; g < DIMS; g++) begin : g_clamp
        fp16_clamp u_clamp (
            .i_val       (w_raw[g]),
            .i_bound_mag (w_bound[g][14:0]),
            .o_val       (w_clamped[g])
        );
    end

    always_ff @(posedge clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            r_c_data <= '0;
            r_c_idx  <= '0;
            r_c_vld  <= 1'b0;
        end else begin
            r_c_vld <= r_vld[MEM_LATENCY-1];
            if (r_vld[MEM_LATENCY-1]) begin
                r_c_data <= w_clamped;
                r_c_idx  <= r_idx[MEM_LATENCY-1];
            end
        end
    end

    assign w_data      = r_c_data;
    assign w_idx       = r_c_idx;
    assign w_vld       = r_c_vld;
    assign w_pipe_busy = (|r_vld) | r_c_vld;
`else
    assign w_data      = mem_data;
    assign w_idx       = r_idx[MEM_LATENCY-1];
    assign w_vld       = r_vld[MEM_LATENCY-1];
    assign w_pipe_busy = |r_vld;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (new_frame) w_next = (w_n == 17'd0) ? DRAIN : FETCH;
            FETCH: if (r_cnt == r_last) w_next = DRAIN;
            DRAIN: if (!w_pipe_busy) w_next = DONE;
            DONE:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && new_frame) begin
                r_cnt  <= '0;
                r_last <= COUNTER_SIZE'(w_n - 17'd1);
            end else if (w_fetch) begin
                r_cnt <= r_cnt + COUNTER_SIZE'(1);
            end
        end
    end

    // Index travels with the read so beats never depend on the live counter
    always_ff @(posedge clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            r_vld <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) r_idx[i] <= '0;
        end else begin
            r_vld[0] <= w_fetch;
            r_idx[0] <= r_cnt;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_idx[i] <= r_idx[i-1];
            end
        end
    end

    always_ff @(posedge clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            particle_data_out  <= '0;
            particle_index_out <= '0;
            valid_particle     <= 1'b0;
            dropped_frames     <= '0;
        end else begin
            valid_particle <= w_vld;
            if (w_vld) begin
                particle_data_out  <= w_data;
                particle_index_out <= w_idx;
            end
            if (new_frame && busy && dropped_frames != 8'hFF)
                dropped_frames <= dropped_frames + 8'd1;
        end
    end
endmodule

// File: tb/tb_particle_streamer.sv
// Directed bench for particle_streamer with a 2-cycle BRAM model.
// Define PARTICLE_STREAM_CLAMP_EN to exercise the clamped build.
module tb_particle_streamer;
    localparam int MAXP = 1024;
`ifdef PARTICLE_STREAM_CLAMP_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic        clk_in = 1'b0;
    logic        sys_rst = 1'b0;
    logic        new_frame = 1'b0;
    logic [15:0] particle_count = '0;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_data = '0;
    logic [31:0] particle_data_out;
    logic [15:0] particle_index_out;
    logic        valid_particle;
    logic        frame_complete;
    logic        busy;
    logic [7:0]  dropped_frames;

    int   n_checks = 0;
    int   n_errors = 0;
    bit   special0 = 1'b0;
    logic [15:0] r_a = '0;

    always #5 clk_in = ~clk_in;

    particle_streamer dut (
        .clk_in             (clk_in),
        .sys_rst            (sys_rst),
        .new_frame          (new_frame),
        .particle_count     (particle_count),
        .mem_addr           (mem_addr),
        .mem_rd_en          (mem_rd_en),
        .mem_data           (mem_data),
        .particle_data_out  (particle_data_out),
        .particle_index_out (particle_index_out),
        .valid_particle     (valid_particle),
        .frame_complete     (frame_complete),
        .busy               (busy),
        .dropped_frames     (dropped_frames)
    );

    function automatic logic [31:0] bram(input logic [15:0] i);
        if (special0 && i == 16'd0) return 32'hC500_4200;
        return {16'h3C00 + i, 16'h4000 + i};
    endfunction

    always @(posedge clk_in) begin
        r_a      <= mem_addr;
        mem_data <= bram(r_a);
    end

    function automatic logic [15:0] lim(input logic [15:0] v);
`ifdef PARTICLE_STREAM_CLAMP_EN
        if (v[14:0] > 15'h4000 || v[14:10] == 5'h1F) return {v[15], 15'h4000};
`endif
        return v;
    endfunction

    function automatic logic [31:0] exp_data(input int i);
        logic [31:0] w;
        w = bram(16'(i));
        return {lim(w[31:16]), lim(w[15:0])};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_rd"}, 32'(mem_rd_en), 32'd0);
        chk({tag, "_data"}, particle_data_out, 32'd0);
        chk({tag, "_idx"}, 32'(particle_index_out), 32'd0);
        chk({tag, "_vld"}, 32'(valid_particle), 32'd0);
        chk({tag, "_fc"}, 32'(frame_complete), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_drop"}, 32'(dropped_frames), 32'd0);
    endtask

    task automatic run_frame(input int cnt, input int drop_a, input bit drop_fc);
        int n, fc, beats;
        n     = (cnt > MAXP) ? MAXP : cnt;
        fc    = (n == 0) ? 2 : LAT + n;
        beats = 0;
        @(negedge clk_in);
        new_frame      = 1'b1;
        particle_count = 16'(cnt);
        for (int k = 1; k <= fc + 1; k++) begin
            @(negedge clk_in);
            chk("busy", 32'(busy), 32'(k <= fc));
            chk("fc", 32'(frame_complete), 32'(k == fc));
            chk("valid", 32'(valid_particle), 32'(k >= LAT && k < LAT + n));
            chk("rd_en", 32'(mem_rd_en), 32'(k <= n));
            if (k <= n) chk("addr", 32'(mem_addr), 32'(k - 1));
            if (valid_particle) begin
                chk("idx", 32'(particle_index_out), 32'(beats));
                chk("data", particle_data_out, exp_data(beats));
                beats++;
            end
            new_frame = (k == drop_a) || (drop_fc && k == fc);
            if (k == 2) particle_count = 16'd7;
        end
        chk("beats", 32'(beats), 32'(n));
        if (n > 0) begin
            chk("hold_idx", 32'(particle_index_out), 32'(n - 1));
            chk("hold_data", particle_data_out, exp_data(n - 1));
        end
    endtask

    initial begin
        sys_rst = 1'b1;
        #1;
        chk_zero("rst");
        repeat (2) @(negedge clk_in);
        sys_rst = 1'b0;

        run_frame(4, 0, 1'b0);
        run_frame(0, 0, 1'b0);
        chk("drop0", 32'(dropped_frames), 32'd0);
        run_frame(20, 5, 1'b1);
        chk("drop2", 32'(dropped_frames), 32'd2);
        run_frame(2000, 0, 1'b0);

        @(negedge clk_in);
        new_frame      = 1'b1;
        particle_count = 16'd20;
        for (int k = 1; k <= LAT + 8; k++) begin
            @(negedge clk_in);
            new_frame = 1'b0;
        end
        chk("pre_rst_idx", 32'(particle_index_out), 32'd8);
        sys_rst = 1'b1;
        #1;
        chk_zero("mid_rst");
        repeat (2) @(negedge clk_in);
        sys_rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk_in);
            chk("post_rst_vld", 32'(valid_particle), 32'd0);
        end
        run_frame(3, 0, 1'b0);

`ifdef PARTICLE_STREAM_CLAMP_EN
        special0 = 1'b1;
        run_frame(1, 0, 1'b0);
        chk("clamp_val", particle_data_out, 32'hC000_4000);
        special0 = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
